lagarto_l15_req_arbiter: RTL and testbench
==========================================

Name: lagarto_l15_req_arbiter

Overview:
- Shares the single L1.5 request channel of a Lagarto tile between NUM_REQ core-side requesters: 0 = icache, 1 = dcache, 2 = PTW.
- Round-robin arbitration; holds the granted request stable until the L1.5 header ack.
- Tags each accepted request with a transaction ID from a free pool and steers each L1.5 return to its owner by that ID.
- Sits between the Lagarto memory clients and the wt_cache_pkg l15_req/l15_rtrn adapter.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- ADDR_W, 40: physical address width.
- TID_W, 2: transaction ID width; 2**TID_W IDs in flight.
- RTRN_W, 128: return data width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_val_i  in  NUM_REQ  per-requester request valid.
- req_addr_i  in  NUM_REQ*ADDR_W  request address.
- req_type_i  in  NUM_REQ*5  L1.5 rqtype.
- req_size_i  in  NUM_REQ*3  L1.5 size code.
- req_data_i  in  NUM_REQ*64  store data.
- req_ack_o  out  NUM_REQ  one-cycle accept pulse.
- l15_val_o  out  1  request valid to L1.5.
- l15_addr_o  out  ADDR_W  granted address.
- l15_type_o  out  5  granted rqtype.
- l15_size_o  out  3  granted size.
- l15_data_o  out  64  granted data.
- l15_id_o  out  TID_W  allocated transaction ID.
- l15_ack_i  in  1  header accepted by L1.5.
- rtrn_val_i  in  1  L1.5 return valid.
- rtrn_id_i  in  TID_W  return transaction ID.
- rtrn_type_i  in  4  return type.
- rtrn_data_i  in  RTRN_W  return data.
- rtrn_val_o  out  NUM_REQ  one-hot return valid to owner.
- rtrn_type_o  out  4  return type, broadcast.
- rtrn_data_o  out  RTRN_W  return data, broadcast.
- busy_o  out  1  any ID in use or request pending.
- id_err_o  out  1  sticky: return with unallocated ID.

Behaviour:
- Reset: all outputs 0. FSM = IDLE. RR pointer = 0. ID-in-use vector and owner table cleared. id_err_o cleared. A reset during a pending request drops it: no req_ack_o, l15_val_o low the next cycle.
- Requester protocol: hold req_val_i and payload stable until its req_ack_o. Deasserting earlier is illegal and not checked.
- FSM IDLE:
  - Grant is allowed when any req_val_i is set and at least one ID is free, evaluated on the registered in-use vector.
  - Winner = first requester with req_val_i set at or after the RR pointer, wrapping.
  - Register the winner's payload and the lowest-numbered free ID; go to REQ.
  - l15_val_o rises the cycle after grant (1-cycle latency).
- FSM REQ:
  - l15_val_o = 1; all l15_* outputs held stable.
  - On l15_ack_i: pulse req_ack_o[winner] in that same cycle; mark the ID in use with owner = winner; RR pointer = winner+1 mod NUM_REQ; go to IDLE; l15_val_o = 0 the next cycle.
  - Back-to-back throughput is one request per 2 cycles minimum.
- Returns (combinational path):
  - rtrn_val_o[owner[rtrn_id_i]] = rtrn_val_i when that ID is in use; rtrn_type_o and rtrn_data_o pass through.
  - The ID is freed at the clock edge. A freed ID becomes grantable from the next cycle only.
  - A return on an unused ID drives no rtrn_val_o and sets id_err_o until reset.
- Simultaneous events:
  - Return-free and ack-allocate in the same cycle always touch different IDs; both take effect.
  - A return for a just-acked ID cannot arrive in the ack cycle (L1.5 guarantee).
- Pool full (all IDs in use): FSM stays in IDLE, requesters stall, no acks.
- busy_o = (FSM == REQ) | (|in_use).

Test Plan:
- Single request: req_val_i[1] with addr 0x80001000, type 0 → l15_val_o the next cycle with l15_id_o = 0; l15_ack_i 2 cycles later → req_ack_o = 3'b010 that cycle; l15_val_o drops the next cycle.
- Round-robin: all three req_val_i held, ack every REQ cycle → grant order 0,1,2,0 with IDs 0,1,2,3.
- Pool exhaustion: 4 accepted, no returns → 5th request stalls with l15_val_o = 0. Return id 2 → next grant uses id 2, starting one cycle after the return.
- Return steering: id 1 owned by requester 2, rtrn_val_i with rtrn_id_i = 1, data 0xDEAD… → rtrn_val_o = 3'b100 with matching data. Stray return on a free id 3 → rtrn_val_o = 0 and id_err_o = 1.
- Stability and reset: l15_ack_i held low for 10 cycles → l15_* outputs unchanged throughout. Assert rst_i mid-REQ → next cycle all outputs 0, no ack issued, in-use vector cleared.

Source files
------------

// File: rtl/lagarto_l15_req_arbiter.sv
// Round-robin arbiter sharing one L1.5 request channel among core-side requesters.
// Tags accepted requests with a free transaction ID and steers returns to the owner.
module lagarto_l15_req_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 40,
   parameter int TID_W   = 2,
   parameter int RTRN_W  = 128
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_val_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*5-1:0]      req_type_i,
   input  logic [NUM_REQ*3-1:0]      req_size_i,
   input  logic [NUM_REQ*64-1:0]     req_data_i,
   output logic [NUM_REQ-1:0]        req_ack_o,
   output logic                      l15_val_o,
   output logic [ADDR_W-1:0]         l15_addr_o,
   output logic [4:0]                l15_type_o,
   output logic [2:0]                l15_size_o,
   output logic [63:0]               l15_data_o,
   output logic [TID_W-1:0]          l15_id_o,
   input  logic                      l15_ack_i,
   input  logic                      rtrn_val_i,
   input  logic [TID_W-1:0]          rtrn_id_i,
   input  logic [3:0]                rtrn_type_i,
   input  logic [RTRN_W-1:0]         rtrn_data_i,
   output logic [NUM_REQ-1:0]        rtrn_val_o,
   output logic [3:0]                rtrn_type_o,
   output logic [RTRN_W-1:0]         rtrn_data_o,
   output logic                      busy_o,
   output logic                      id_err_o
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int NUM_ID = 1 << TID_W;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_e;

   state_e                          state_q, state_d;
   logic [IDX_W-1:0]                rr_q, rr_d;
   logic [IDX_W-1:0]                winner_q, winner_d;
   logic [NUM_ID-1:0]               in_use_q, in_use_d;
   logic [NUM_ID-1:0][IDX_W-1:0]    owner_q, owner_d;
   logic [ADDR_W-1:0]               addr_q, addr_d;
   logic [4:0]                      type_q, type_d;
   logic [2:0]                      size_q, size_d;
   logic [63:0]                     data_q, data_d;
   logic [TID_W-1:0]                id_q, id_d;
   logic                            id_err_q, id_err_d;

   logic [ADDR_W-1:0]               addr_arr [NUM_REQ];
   logic [4:0]                      type_arr [NUM_REQ];
   logic [2:0]                      size_arr [NUM_REQ];
   logic [63:0]                     data_arr [NUM_REQ];

   logic                            grant_hit;
   logic [IDX_W-1:0]                grant_idx;
   logic                            free_hit;
   logic [TID_W-1:0]                free_id;
   logic                            ack_fire;
   logic                            rtrn_hit;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g] = req_addr_i[g*ADDR_W +: ADDR_W];
      assign type_arr[g] = req_type_i[g*5 +: 5];
      assign size_arr[g] = req_size_i[g*3 +: 3];
      assign data_arr[g] = req_data_i[g*64 +: 64];
   end

   function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return IDX_W'(sum);
   endfunction

   // Round-robin search starting at the pointer, wrapping past the last requester.
   always_comb begin
      grant_hit = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_hit && req_val_i[rr_index(rr_q, i)]) begin
            grant_hit = 1'b1;
            grant_idx = rr_index(rr_q, i);
         end
      end
   end

   always_comb begin
      free_hit = 1'b0;
      free_id  = '0;
      for (int j = NUM_ID - 1; j >= 0; j--) begin
         if (!in_use_q[TID_W'(j)]) begin
            free_hit = 1'b1;
            free_id  = TID_W'(j);
         end
      end
   end

   assign ack_fire = (state_q == REQ) && l15_ack_i;
   assign rtrn_hit = rtrn_val_i && in_use_q[rtrn_id_i];

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      winner_d = winner_q;
      in_use_d = in_use_q;
      owner_d  = owner_q;
      addr_d   = addr_q;
      type_d   = type_q;
      size_d   = size_q;
      data_d   = data_q;
      id_d     = id_q;
      id_err_d = id_err_q;

      // Returns free their ID at this edge; the allocation below never targets the same ID.
      if (rtrn_hit) in_use_d[rtrn_id_i] = 1'b0;
      if (rtrn_val_i && !in_use_q[rtrn_id_i]) id_err_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (grant_hit && free_hit) begin
               state_d  = REQ;
               winner_d = grant_idx;
               addr_d   = addr_arr[grant_idx];
               type_d   = type_arr[grant_idx];
               size_d   = size_arr[grant_idx];
               data_d   = data_arr[grant_idx];
               id_d     = free_id;
            end
         end
         REQ: begin
            if (l15_ack_i) begin
               state_d          = IDLE;
               in_use_d[id_q]   = 1'b1;
               owner_d[id_q]    = winner_q;
               rr_d             = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         rr_q     <= '0;
         winner_q <= '0;
         in_use_q <= '0;
         owner_q  <= '0;
         addr_q   <= '0;
         type_q   <= '0;
         size_q   <= '0;
         data_q   <= '0;
         id_q     <= '0;
         id_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         winner_q <= winner_d;
         in_use_q <= in_use_d;
         owner_q  <= owner_d;
         addr_q   <= addr_d;
         type_q   <= type_d;
         size_q   <= size_d;
         data_q   <= data_d;
         id_q     <= id_d;
         id_err_q <= id_err_d;
      end
   end

   // Combinational outputs are forced low while reset is held so a pending ack is dropped.
   always_comb begin
      req_ack_o = '0;
      if (ack_fire && !rst_i) req_ack_o[winner_q] = 1'b1;
   end

   always_comb begin
      rtrn_val_o = '0;
      if (rtrn_hit && !rst_i) rtrn_val_o[owner_q[rtrn_id_i]] = 1'b1;
   end

   assign rtrn_type_o = rst_i ? '0 : rtrn_type_i;
   assign rtrn_data_o = rst_i ? '0 : rtrn_data_i;

   assign l15_val_o  = (state_q == REQ);
   assign l15_addr_o = addr_q;
   assign l15_type_o = type_q;
   assign l15_size_o = size_q;
   assign l15_data_o = data_q;
   assign l15_id_o   = id_q;
   assign busy_o     = (state_q == REQ) || (|in_use_q);
   assign id_err_o   = id_err_q;

endmodule

// File: tb/tb_lagarto_l15_req_arbiter.sv
// Testbench for lagarto_l15_req_arbiter: vector table, directed corner sequences
// and randomized traffic compared against a transaction-level reference model.
module tb_lagarto_l15_req_arbiter;

   localparam int NUM_REQ = 3;
   localparam int ADDR_W  = 40;
   localparam int TID_W   = 2;
   localparam int RTRN_W  = 128;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_val;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*5-1:0]      req_type;
   logic [NUM_REQ*3-1:0]      req_size;
   logic [NUM_REQ*64-1:0]     req_data;
   logic [NUM_REQ-1:0]        req_ack_o;
   logic                      l15_val_o;
   logic [ADDR_W-1:0]         l15_addr_o;
   logic [4:0]                l15_type_o;
   logic [2:0]                l15_size_o;
   logic [63:0]               l15_data_o;
   logic [TID_W-1:0]          l15_id_o;
   logic                      l15_ack;
   logic                      rtrn_val;
   logic [TID_W-1:0]          rtrn_id;
   logic [3:0]                rtrn_type;
   logic [RTRN_W-1:0]         rtrn_data;
   logic [NUM_REQ-1:0]        rtrn_val_o;
   logic [3:0]                rtrn_type_o;
   logic [RTRN_W-1:0]         rtrn_data_o;
   logic                      busy_o;
   logic                      id_err_o;

   int errors = 0;
   int checks = 0;

   lagarto_l15_req_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .TID_W(TID_W), .RTRN_W(RTRN_W)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_val_i(req_val), .req_addr_i(req_addr), .req_type_i(req_type),
      .req_size_i(req_size), .req_data_i(req_data), .req_ack_o(req_ack_o),
      .l15_val_o(l15_val_o), .l15_addr_o(l15_addr_o), .l15_type_o(l15_type_o),
      .l15_size_o(l15_size_o), .l15_data_o(l15_data_o), .l15_id_o(l15_id_o),
      .l15_ack_i(l15_ack),
      .rtrn_val_i(rtrn_val), .rtrn_id_i(rtrn_id), .rtrn_type_i(rtrn_type),
      .rtrn_data_i(rtrn_data),
      .rtrn_val_o(rtrn_val_o), .rtrn_type_o(rtrn_type_o), .rtrn_data_o(rtrn_data_o),
      .busy_o(busy_o), .id_err_o(id_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Fixed per-requester payloads used by the table and directed sequences.
   logic [ADDR_W-1:0] pa [NUM_REQ];
   logic [4:0]        pt [NUM_REQ];
   logic [2:0]        ps [NUM_REQ];
   logic [63:0]       pd [NUM_REQ];

   task automatic load_fixed();
      pa[0] = 40'h00_8000_0000; pa[1] = 40'h00_8000_1000; pa[2] = 40'h00_8000_2000;
      pt[0] = 5'd2;             pt[1] = 5'd0;             pt[2] = 5'd3;
      ps[0] = 3'd1;             ps[1] = 3'd2;             ps[2] = 3'd3;
      pd[0] = 64'hD000_0000_0000_0000;
      pd[1] = 64'hD000_0000_0000_0001;
      pd[2] = 64'hD000_0000_0000_0002;
      for (int r = 0; r < NUM_REQ; r++) begin
         req_addr[r*ADDR_W +: ADDR_W] = pa[r];
         req_type[r*5 +: 5]           = pt[r];
         req_size[r*3 +: 3]           = ps[r];
         req_data[r*64 +: 64]         = pd[r];
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_val = '0; l15_ack = 1'b0; rtrn_val = 1'b0; rtrn_id = '0;
      rtrn_type = '0; rtrn_data = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic       rst;
      logic [2:0] req;
      logic       ack;
      logic       rv;
      logic [1:0] rid;
      logic       ev;
      int         ew;
      logic [1:0] eid;
      logic [2:0] eack;
      logic [2:0] ertrn;
      logic       ebusy;
      logic       eerr;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic [2:0] rq, input logic a,
                               input logic rv, input logic [1:0] rid, input logic ev,
                               input int ew, input logic [1:0] eid, input logic [2:0] eack,
                               input logic [2:0] ertrn, input logic eb, input logic ee);
      tbl.push_back('{r, rq, a, rv, rid, ev, ew, eid, eack, ertrn, eb, ee});
   endfunction

   // Reference model state: pending grant, ID pool, owners, pointer, sticky error.
   bit               m_inuse [4];
   int               m_owner [4];
   int               m_rr;
   bit               m_err;
   bit               m_pend;
   int               m_who;
   logic [1:0]       m_id;
   logic [ADDR_W-1:0] m_addr;
   logic [4:0]       m_type;
   logic [2:0]       m_size;
   logic [63:0]      m_data;
   bit               act [NUM_REQ];

   task automatic model_reset();
      for (int j = 0; j < 4; j++) begin m_inuse[j] = 0; m_owner[j] = 0; end
      for (int r = 0; r < NUM_REQ; r++) act[r] = 0;
      m_rr = 0; m_err = 0; m_pend = 0; m_who = 0; m_id = '0;
      m_addr = '0; m_type = '0; m_size = '0; m_data = '0;
   endtask

   task automatic model_step();
      bit old_inuse [4];
      int win;
      int fid;
      old_inuse = m_inuse;
      if (m_pend) begin
         if (l15_ack) begin
            act[m_who]      = 0;
            m_inuse[m_id]   = 1;
            m_owner[m_id]   = m_who;
            m_rr            = (m_who + 1) % NUM_REQ;
            m_pend          = 0;
         end
      end else begin
         win = -1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (win < 0 && req_val[(m_rr + i) % NUM_REQ]) win = (m_rr + i) % NUM_REQ;
         end
         fid = -1;
         for (int j = 3; j >= 0; j--) if (!old_inuse[j]) fid = j;
         if (win >= 0 && fid >= 0) begin
            m_pend = 1;
            m_who  = win;
            m_id   = 2'(fid);
            m_addr = req_addr[win*ADDR_W +: ADDR_W];
            m_type = req_type[win*5 +: 5];
            m_size = req_size[win*3 +: 3];
            m_data = req_data[win*64 +: 64];
         end
      end
      if (rtrn_val) begin
         if (old_inuse[rtrn_id]) m_inuse[rtrn_id] = 0;
         else m_err = 1;
      end
   endtask

   task automatic rand_payload(input int r);
      req_addr[r*ADDR_W +: ADDR_W] = ADDR_W'({$urandom(), $urandom()});
      req_type[r*5 +: 5]           = 5'($urandom());
      req_size[r*3 +: 3]           = 3'($urandom());
      req_data[r*64 +: 64]         = {$urandom(), $urandom()};
   endtask

   initial begin
      logic [2:0] e_ack;
      logic [2:0] e_rv;
      logic [1:0] rid;
      bit         any;

      rst = 1'b1; req_val = '0; l15_ack = 1'b0; rtrn_val = 1'b0; rtrn_id = '0;
      rtrn_type = '0; rtrn_data = '0; req_addr = '0; req_type = '0; req_size = '0;
      req_data = '0;
      load_fixed();

      //   rst req     ack rv rid  ev ew eid eack    ertrn   busy err
      add(0, 3'b010, 0, 0, 2'd0, 0, 0, 2'd0, 3'b000, 3'b000, 0, 0);
      add(0, 3'b010, 0, 0, 2'd0, 1, 1, 2'd0, 3'b000, 3'b000, 1, 0);
      add(0, 3'b010, 0, 0, 2'd0, 1, 1, 2'd0, 3'b000, 3'b000, 1, 0);
      add(0, 3'b010, 1, 0, 2'd0, 1, 1, 2'd0, 3'b010, 3'b000, 1, 0);
      add(0, 3'b000, 0, 0, 2'd0, 0, 0, 2'd0, 3'b000, 3'b000, 1, 0);
      add(1, 3'b000, 0, 0, 2'd0, 0, 0, 2'd0, 3'b000, 3'b000, 1, 0);
      add(0, 3'b111, 0, 0, 2'd0, 0, 0, 2'd0, 3'b000, 3'b000, 0, 0);
      add(0, 3'b111, 1, 0, 2'd0, 1, 0, 2'd0, 3'b001, 3'b000, 1, 0);
      add(0, 3'b111, 0, 0, 2'd0, 0, 0, 2'd0, 3'b000, 3'b000, 1, 0);
      add(0, 3'b111, 1, 0, 2'd0, 1, 1, 2'd1, 3'b010, 3'b000, 1, 0);
      add(0, 3'b111, 0, 0, 2'd0, 0, 0, 2'd0, 3'b000, 3'b000, 1, 0);
      add(0, 3'b111, 1, 0, 2'd0, 1, 2, 2'd2, 3'b100, 3'b000, 1, 0);
      add(0, 3'b111, 0, 0, 2'd0, 0, 0, 2'd0, 3'b000, 3'b000, 1, 0);
      add(0, 3'b111, 1, 0, 2'd0, 1, 0, 2'd3, 3'b001, 3'b000, 1, 0);
      add(0, 3'b111, 0, 0, 2'd0, 0, 0, 2'd0, 3'b000, 3'b000, 1, 0);
      add(0, 3'b111, 0, 0, 2'd0, 0, 0, 2'd0, 3'b000, 3'b000, 1, 0);
      add(0, 3'b111, 0, 1, 2'd2, 0, 0, 2'd0, 3'b000, 3'b100, 1, 0);
      add(0, 3'b111, 0, 0, 2'd0, 0, 0, 2'd0, 3'b000, 3'b000, 1, 0);
      add(0, 3'b111, 1, 0, 2'd0, 1, 1, 2'd2, 3'b010, 3'b000, 1, 0);
      add(0, 3'b000, 0, 1, 2'd1, 0, 0, 2'd0, 3'b000, 3'b010, 1, 0);
      add(0, 3'b000, 0, 1, 2'd0, 0, 0, 2'd0, 3'b000, 3'b001, 1, 0);
      add(0, 3'b000, 0, 1, 2'd3, 0, 0, 2'd0, 3'b000, 3'b001, 1, 0);
      add(0, 3'b000, 0, 1, 2'd2, 0, 0, 2'd0, 3'b000, 3'b010, 1, 0);
      add(0, 3'b000, 0, 0, 2'd0, 0, 0, 2'd0, 3'b000, 3'b000, 0, 0);
      add(0, 3'b000, 0, 1, 2'd3, 0, 0, 2'd0, 3'b000, 3'b000, 0, 0);
      add(0, 3'b000, 0, 0, 2'd0, 0, 0, 2'd0, 3'b000, 3'b000, 0, 1);

      do_reset();
      #1;
      chk("reset_state", {l15_val_o, l15_addr_o, l15_type_o, l15_size_o, l15_data_o, l15_id_o,
                          req_ack_o, rtrn_val_o, busy_o, id_err_o}, '0);

      for (int k = 0; k < tbl.size(); k++) begin
         @(negedge clk);
         rst = tbl[k].rst; req_val = tbl[k].req; l15_ack = tbl[k].ack;
         rtrn_val = tbl[k].rv; rtrn_id = tbl[k].rid; rtrn_type = 4'h2;
         rtrn_data = {32'hDEAD_BEEF, 94'h0, tbl[k].rid};
         #1;
         chk($sformatf("vec%0d_ctl", k), {l15_val_o, req_ack_o, rtrn_val_o, busy_o, id_err_o},
             {tbl[k].ev, tbl[k].eack, tbl[k].ertrn, tbl[k].ebusy, tbl[k].eerr});
         if (tbl[k].ev)
            chk($sformatf("vec%0d_payload", k),
                {l15_addr_o, l15_type_o, l15_size_o, l15_data_o, l15_id_o},
                {pa[tbl[k].ew], pt[tbl[k].ew], ps[tbl[k].ew], pd[tbl[k].ew], tbl[k].eid});
      end

      // Hold stability with ack withheld, then reset in the middle of a pending request.
      do_reset();
      req_val = 3'b010;
      @(negedge clk); l15_ack = 1'b1;
      @(negedge clk); l15_ack = 1'b0; req_val = 3'b100;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 3) req_val = 3'b101;
         #1;
         chk($sformatf("hold%0d", i),
             {l15_val_o, l15_addr_o, l15_type_o, l15_size_o, l15_data_o, l15_id_o, req_ack_o},
             {1'b1, pa[2], pt[2], ps[2], pd[2], 2'd1, 3'b000});
      end
      @(negedge clk); rst = 1'b1; l15_ack = 1'b1;
      #1;
      chk("rst_noack", {29'h0, req_ack_o}, '0);
      @(negedge clk); rst = 1'b0; l15_ack = 1'b0; req_val = 3'b001;
      #1;
      chk("rst_clear", {l15_val_o, l15_addr_o, l15_type_o, l15_size_o, l15_data_o, l15_id_o,
                        req_ack_o, rtrn_val_o, busy_o, id_err_o}, '0);
      @(negedge clk);
      #1;
      chk("post_rst_id", {l15_val_o, l15_id_o, l15_addr_o}, {1'b1, 2'd0, pa[0]});

      // Return steering: ID 1 owned by requester 2, then a stray return on free ID 3.
      do_reset();
      req_val = 3'b001;
      @(negedge clk); l15_ack = 1'b1;
      #1;
      chk("steer_ack0", {29'h0, req_ack_o}, {29'h0, 3'b001});
      @(negedge clk); l15_ack = 1'b0; req_val = 3'b100;
      @(negedge clk); l15_ack = 1'b1;
      #1;
      chk("steer_grant2", {l15_val_o, l15_id_o, req_ack_o}, {1'b1, 2'd1, 3'b100});
      @(negedge clk); l15_ack = 1'b0; req_val = '0;
      rtrn_val = 1'b1; rtrn_id = 2'd1; rtrn_type = 4'h5;
      rtrn_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
      #1;
      chk("steer_rtrn", {rtrn_val_o, rtrn_type_o, rtrn_data_o},
          {3'b100, 4'h5, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE});
      @(negedge clk); rtrn_id = 2'd3;
      #1;
      chk("stray_rtrn", {29'h0, rtrn_val_o}, '0);
      @(negedge clk); rtrn_val = 1'b0;
      #1;
      chk("stray_err", {255'h0, id_err_o}, {255'h0, 1'b1});

      // Randomized traffic against the reference model.
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(negedge clk);
         for (int r = 0; r < NUM_REQ; r++) begin
            if (!act[r] && $urandom_range(0, 2) == 0) begin
               act[r] = 1;
               rand_payload(r);
            end
            req_val[r] = act[r];
         end
         l15_ack   = m_pend && ($urandom_range(0, 1) == 1);
         rid       = 2'($urandom_range(0, 3));
         rtrn_id   = rid;
         rtrn_val  = ($urandom_range(0, 2) == 0) && (m_inuse[rid] || $urandom_range(0, 59) == 0);
         rtrn_type = 4'($urandom());
         rtrn_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         #1;
         e_ack = (m_pend && l15_ack) ? 3'(1 << m_who) : 3'b000;
         e_rv  = (rtrn_val && m_inuse[rid]) ? 3'(1 << m_owner[rid]) : 3'b000;
         any = 0;
         for (int j = 0; j < 4; j++) any |= m_inuse[j];
         chk("rand_ctl",
             {l15_val_o, l15_addr_o, l15_type_o, l15_size_o, l15_data_o, l15_id_o,
              req_ack_o, rtrn_val_o, busy_o, id_err_o},
             {m_pend, m_addr, m_type, m_size, m_data, m_id, e_ack, e_rv, m_pend | any, m_err});
         chk("rand_rtrn", {rtrn_type_o, rtrn_data_o}, {rtrn_type, rtrn_data});
         @(posedge clk);
         model_step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
